// File: rtl/voice_envelope_mixer_if.sv
// Voice envelope mixer bus: voice/key inputs and mixed output plus debug levels.
interface voice_envelope_mixer_if;
  logic [3:0] gen;
  logic [3:0] button;
  logic [7:0] dac;
  logic [3:0] active;
  logic [7:0] env0;
  logic [7:0] env1;
  logic [7:0] env2;
  logic [7:0] env3;

  // Stimulus side: drives voices and keys, observes the mixer.
  modport master (
    output gen, button,
    input  dac, active, env0, env1, env2, env3
  );

  // Mixer side.
  modport slave (
    input  gen, button,
    output dac, active, env0, env1, env2, env3
  );
endinterface

// File: rtl/voice_envelope_mixer.sv
// Four-voice envelope mixer: debounced keys drive per-voice attack/release
// envelopes that scale the square-wave voices into a saturated 8-bit DAC level.
module voice_envelope_mixer #(
  parameter int         STEP_DIV   = 50000,
  parameter int         DEB_CYCLES = 500000,
  parameter int         ATK_STEP   = 8,
  parameter int         REL_STEP   = 4,
  parameter logic [7:0] W0         = 8'd16,
  parameter logic [7:0] W1         = 8'd32,
  parameter logic [7:0] W2         = 8'd64,
  parameter logic [7:0] W3         = 8'd128
) (
  input logic                   clk,
  input logic                   rst,
  voice_envelope_mixer_if.slave bus
);

  localparam int              TW        = $clog2(STEP_DIV);
  localparam int              DW        = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [8:0]      ATK9      = 9'(ATK_STEP);
  localparam logic [8:0]      REL9      = 9'(REL_STEP);
  localparam logic [7:0]      WEIGHT [4] = '{W0, W1, W2, W3};

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  logic [3:0]    sync1, sync2, key_db;
  logic [DW-1:0] deb_cnt [4];
  logic [TW-1:0] tick_cnt;
  logic          tick;
  env_state_t    state [4];
  logic [7:0]    env [4];
  logic [7:0]    env_up [4];
  logic [7:0]    env_dn [4];
  logic [7:0]    scaled [4];
  logic [3:0]    active;
  logic [7:0]    contrib [4];
  logic [9:0]    mix_sum;
  logic [7:0]    dac;

  // Two-flop synchronizer for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking so sync2 captures last cycle's sync1, giving two real stages.
      sync1 <= bus.button;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a new key level only after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_db <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != key_db[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            key_db[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Free-running envelope tick divider.
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Clamped 9-bit step arithmetic and weight scaling for each voice.
  always_comb begin
    logic [8:0] sum9;
    logic [8:0] dif9;
    // NOTE: every variable gets a value on every path so no latch is inferred.
    sum9 = '0;
    dif9 = '0;
    for (int i = 0; i < 4; i++) begin
      sum9      = {1'b0, env[i]} + ATK9;
      dif9      = {1'b0, env[i]} - REL9;
      env_up[i] = sum9[8] ? 8'hFF : sum9[7:0];
      env_dn[i] = dif9[8] ? 8'h00 : dif9[7:0];
      scaled[i] = 8'((16'(WEIGHT[i]) * 16'(env[i])) >> 8);
    end
  end

  // Per-voice envelope FSM; level moves only on tick, key transitions every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state/env arrays are plain flops (not RAM), so resetting them all is legitimate.
      active <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        env[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (state[i])
          IDLE: begin
            env[i]    <= '0;
            active[i] <= key_db[i];
            if (key_db[i]) state[i] <= ATTACK;
          end
          ATTACK: begin
            active[i] <= 1'b1;
            if (tick) env[i] <= env_up[i];
            if (!key_db[i])                       state[i] <= RELEASE;
            else if (tick && env_up[i] == 8'hFF)  state[i] <= SUSTAIN;
          end
          SUSTAIN: begin
            active[i] <= 1'b1;
            env[i]    <= 8'hFF;
            if (!key_db[i]) state[i] <= RELEASE;
          end
          default: begin  // RELEASE
            if (tick) env[i] <= env_dn[i];
            if (key_db[i]) begin
              state[i]  <= ATTACK;
              active[i] <= 1'b1;
            end else if (tick && env_dn[i] == 8'h00) begin
              state[i]  <= IDLE;
              active[i] <= 1'b0;
            end else begin
              active[i] <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Mix stage 1: gate each scaled envelope with its square-wave voice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) contrib[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) contrib[i] <= bus.gen[i] ? scaled[i] : 8'h00;
    end
  end

  assign mix_sum = 10'(contrib[0]) + 10'(contrib[1]) + 10'(contrib[2]) + 10'(contrib[3]);

  // Mix stage 2: saturating sum into the DAC register.
  always_ff @(posedge clk) begin
    if (rst) dac <= '0;
    else     dac <= (mix_sum > 10'd255) ? 8'hFF : mix_sum[7:0];
  end

  assign bus.dac    = dac;
  assign bus.active = active;
  assign bus.env0   = env[0];
  assign bus.env1   = env[1];
  assign bus.env2   = env[2];
  assign bus.env3   = env[3];

endmodule

// File: tb/tb_voice_envelope_mixer.sv
// Self-checking bench for voice_envelope_mixer: directed scenarios plus random
// keys/voices, compared every cycle against a behavioural model.
module tb_voice_envelope_mixer;

  localparam int STEP_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int ATK_STEP   = 64;
  localparam int REL_STEP   = 32;

  // Model envelope phases.
  localparam int P_OFF  = 0;
  localparam int P_RISE = 1;
  localparam int P_HOLD = 2;
  localparam int P_FALL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gen_drv;
  logic [3:0] btn_drv;

  always #5 clk = ~clk;

  voice_envelope_mixer_if bus_a ();
  voice_envelope_mixer_if bus_b ();

  assign bus_a.gen    = gen_drv;
  assign bus_a.button = btn_drv;
  assign bus_b.gen    = gen_drv;
  assign bus_b.button = btn_drv;

  // Default weights.
  voice_envelope_mixer #(
    .STEP_DIV(STEP_DIV), .DEB_CYCLES(DEB_CYCLES), .ATK_STEP(ATK_STEP), .REL_STEP(REL_STEP)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  // All weights at 255 to exercise saturation.
  voice_envelope_mixer #(
    .STEP_DIV(STEP_DIV), .DEB_CYCLES(DEB_CYCLES), .ATK_STEP(ATK_STEP), .REL_STEP(REL_STEP),
    .W0(8'd255), .W1(8'd255), .W2(8'd255), .W3(8'd255)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_n;          // non-reset edges since last reset
  logic [3:0]  m_s1, m_s2, m_kdb;
  int          m_run [4];
  int          m_ph  [4];
  int          m_env [4];
  int          m_c   [2][4];
  int          m_dac [2];
  int          wts   [2][4] = '{'{16, 32, 64, 128}, '{255, 255, 255, 255}};

  function automatic void model_reset();
    m_n = 0; m_s1 = '0; m_s2 = '0; m_kdb = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_ph[i] = P_OFF; m_env[i] = 0;
      m_c[0][i] = 0; m_c[1][i] = 0;
    end
    m_dac[0] = 0; m_dac[1] = 0;
  endfunction

  function automatic void model_step();
    bit         tk;
    int         ne [4];
    int         nph [4];
    int         nc [2][4];
    int         nd [2];
    int         sum;
    logic [3:0] nk;
    if (rst) begin
      model_reset();
      return;
    end
    tk = ((m_n % STEP_DIV) == STEP_DIV - 1);
    m_n++;
    nk = m_kdb;
    for (int i = 0; i < 4; i++) begin
      ne[i]  = m_env[i];
      nph[i] = m_ph[i];
      case (m_ph[i])
        P_OFF:  if (m_kdb[i]) nph[i] = P_RISE;
        P_RISE: begin
          if (tk) ne[i] = (m_env[i] + ATK_STEP > 255) ? 255 : m_env[i] + ATK_STEP;
          if (!m_kdb[i])             nph[i] = P_FALL;
          else if (tk && ne[i] == 255) nph[i] = P_HOLD;
        end
        P_HOLD: if (!m_kdb[i]) nph[i] = P_FALL;
        default: begin
          if (tk) ne[i] = (m_env[i] - REL_STEP < 0) ? 0 : m_env[i] - REL_STEP;
          if (m_kdb[i])             nph[i] = P_RISE;
          else if (tk && ne[i] == 0) nph[i] = P_OFF;
        end
      endcase
      for (int w = 0; w < 2; w++)
        nc[w][i] = gen_drv[i] ? (wts[w][i] * m_env[i]) / 256 : 0;
      if (m_s2[i] != m_kdb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB_CYCLES) begin
          nk[i]    = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int w = 0; w < 2; w++) begin
      sum = m_c[w][0] + m_c[w][1] + m_c[w][2] + m_c[w][3];
      nd[w] = (sum > 255) ? 255 : sum;
    end
    m_s2  = m_s1;
    m_s1  = btn_drv;
    m_kdb = nk;
    m_env = ne;
    m_ph  = nph;
    m_c   = nc;
    m_dac = nd;
  endfunction

  function automatic logic [3:0] exp_active();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = (m_ph[i] != P_OFF);
    return a;
  endfunction

  function automatic logic [31:0] exp_env();
    return {8'(m_env[3]), 8'(m_env[2]), 8'(m_env[1]), 8'(m_env[0])};
  endfunction

  // One clock: advance the model at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("dac_a",    bus_a.dac, m_dac[0]);
    check("dac_b",    bus_b.dac, m_dac[1]);
    check("active_a", bus_a.active, exp_active());
    check("env_a",    {bus_a.env3, bus_a.env2, bus_a.env1, bus_a.env0}, exp_env());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]  q [$];
    logic [7:0]  last;
    logic [63:0] seq;
    logic        act_min;
    bit          pressed;
    int          lat;
    int          hold [4];

    model_reset();
    rst = 1'b1; gen_drv = 4'hF; btn_drv = 4'h0;

    // 1. Reset then idle.
    step(); step();
    check("rst_dac", bus_a.dac, 0);
    check("rst_active", bus_a.active, 0);
    check("rst_env", {bus_a.env3, bus_a.env2, bus_a.env1, bus_a.env0}, 0);
    rst = 1'b0;
    repeat (100) step();
    check("idle_dac", bus_a.dac, 0);
    check("idle_env", {bus_a.env3, bus_a.env2, bus_a.env1, bus_a.env0}, 0);

    // 2. Attack/sustain on voice 3.
    gen_drv = 4'b1000; btn_drv[3] = 1'b1;
    lat = 0;
    while (bus_a.active[3] !== 1'b1 && lat < 20) begin step(); lat++; end
    check("atk_latency", lat, 6);
    last = bus_a.env3;
    for (int k = 0; k < 40 && !(q.size() > 0 && q[$] == 8'hFF); k++) begin
      step();
      if (bus_a.env3 !== last) begin q.push_back(bus_a.env3); last = bus_a.env3; end
    end
    seq = '0;
    foreach (q[k]) seq = (seq << 8) | 64'(q[k]);
    check("atk_seq", seq, 64'h40_80_C0_FF);
    repeat (4) step();
    check("sus_env3", bus_a.env3, 255);
    check("sus_dac", bus_a.dac, 127);

    // 3. Release then retrigger mid-release.
    q.delete(); btn_drv[3] = 1'b0; act_min = 1'b1; pressed = 0;
    last = bus_a.env3;
    for (int k = 0; k < 80 && !(pressed && q.size() > 0 && q[$] == 8'hFF); k++) begin
      step();
      act_min &= bus_a.active[3];
      if (bus_a.env3 !== last) begin q.push_back(bus_a.env3); last = bus_a.env3; end
      if (bus_a.env3 == 8'd191 && !pressed) begin btn_drv[3] = 1'b1; pressed = 1; end
    end
    seq = '0;
    foreach (q[k]) seq = (seq << 8) | 64'(q[k]);
    check("rel_retrig_seq", seq, 64'hDF_BF_9F_DF_FF);
    check("rel_active", act_min, 1);

    // 4. Debounce on voice 0.
    gen_drv = 4'b1001;
    btn_drv[0] = 1'b1; step(); btn_drv[0] = 1'b0;
    repeat (8) step();
    check("deb_pulse1", bus_a.active[0], 0);
    btn_drv[0] = 1'b1; repeat (2) step(); btn_drv[0] = 1'b0;
    repeat (8) step();
    check("deb_pulse2", bus_a.active[0], 0);
    btn_drv[0] = 1'b1; repeat (5) step(); btn_drv[0] = 1'b0;
    repeat (2) step();
    check("deb_pulse5", bus_a.active[0], 1);

    // 5. Saturation.
    btn_drv = 4'hF; gen_drv = 4'hF;
    repeat (60) step();
    check("sat_env", {bus_a.env3, bus_a.env2, bus_a.env1, bus_a.env0}, 32'hFFFF_FFFF);
    check("sat_dac_b", bus_b.dac, 255);
    check("sat_dac_a", bus_a.dac, 236);
    gen_drv = 4'h1;
    repeat (3) step();
    check("sat_g1_b", bus_b.dac, 254);
    check("sat_g1_a", bus_a.dac, 15);
    btn_drv = 4'h0;
    repeat (80) step();
    check("all_idle", bus_a.active, 0);

    // 6b. Key release landing on an attack tick at env=128 (voice 1).
    btn_drv[1] = 1'b1; gen_drv = 4'b0010;
    for (int k = 0; k < 60 && !(m_env[1] == 64 && m_ph[1] == P_RISE &&
                                ((m_n + 1) % STEP_DIV) == STEP_DIV - 1); k++)
      step();
    check("sim_setup", bus_a.env1, 64);
    btn_drv[1] = 1'b0;
    repeat (5) step();
    check("sim_pre", bus_a.env1, 128);
    step();
    check("sim_env", bus_a.env1, 192);
    check("sim_act", bus_a.active[1], 1);
    repeat (4) step();
    check("sim_rel", bus_a.env1, 160);

    // 6a. Reset mid-release on voice 2.
    btn_drv[2] = 1'b1; gen_drv = 4'b0100;
    for (int k = 0; k < 60 && m_env[2] != 128; k++) step();
    btn_drv[2] = 1'b0;
    for (int k = 0; k < 80 && !(m_env[2] == 96 && m_ph[2] == P_FALL); k++) step();
    check("rr_setup", bus_a.env2, 96);
    rst = 1'b1; step(); rst = 1'b0;
    check("rr_env2", bus_a.env2, 0);
    check("rr_active", bus_a.active, 0);
    step(); step();
    check("rr_dac", bus_a.dac, 0);

    // Random keys, voices and occasional reset.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          btn_drv[i] = 1'($urandom_range(0, 1));
          hold[i]    = int'($urandom_range(1, 30));
        end else begin
          hold[i]--;
        end
      end
      gen_drv = 4'($urandom);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
